td4_cpu_param: RTL and testbench

Parametrised, single-cycle, accumulator-style 4-bit-class CPU core: the next generation of the team's TD4-class CPU, generalised to DATA_W-bit data and ADDR_W-bit program addresses. The ISA is extended with subtract, zero flag, jump-on-zero, OUT A and halt. Instruction fetch gains a valid/stall handshake so the core can run from a slow or external program memory. It sits between the Tiny Tapeout wrapper pins (instruction bus, input switches, output port) and an external or on-chip ROM addressed by `pc`.

---
 rtl/td4_cpu_param.sv | 134 +++++++++++++
 tb/tb_td4_cpu_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/td4_cpu_param.sv
// Parametrised TD4-class accumulator CPU: single-cycle execution with a
// valid/stall instruction fetch, subtract, zero flag, conditional jumps and halt.
//
// Handshake: instr is consumed on a rising edge only when instr_valid=1 and the
// core is in RUN. There is no ready: when instr_valid=0 the core holds all state.
// In HALT, instr_valid and instr are ignored until rst.
module td4_cpu_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4   // must not exceed DATA_W; jump targets come from im
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [DATA_W+3:0]   instr,
  input  logic [DATA_W-1:0]   in_port,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   out_port,
  output logic                out_strobe,
  output logic                carry,
  output logic                zero,
  output logic                halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic                strobe_q, strobe_d;

  logic [3:0]          op;
  logic [DATA_W-1:0]   im;
  logic [DATA_W-1:0]   sel;
  logic [DATA_W-1:0]   opnd;
  logic                cin;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   r;
  logic                cy;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   target;

  assign op     = instr[DATA_W+3:DATA_W];
  assign im     = instr[DATA_W-1:0];
  assign pc_inc = pc_q + 1'b1;
  assign target = im[ADDR_W-1:0];

  // ALU operand select; SUB is A + ~im + 1 so cy=1 means no borrow.
  always_comb begin
    sel  = '0;
    opnd = im;
    cin  = 1'b0;
    case (op)
      4'b0000, 4'b0100, 4'b1010: sel = a_q;
      4'b0001, 4'b0101, 4'b1001: sel = b_q;
      4'b0010, 4'b0110:          sel = in_port;
      4'b1000: begin
        sel  = a_q;
        opnd = ~im;
        cin  = 1'b1;
      end
      default:                   sel = '0;
    endcase
    sum = {1'b0, sel} + {1'b0, opnd} + {{DATA_W{1'b0}}, cin};
    r   = sum[DATA_W-1:0];
    cy  = sum[DATA_W];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    pc_d     = pc_q;
    c_d      = c_q;
    z_d      = z_q;
    strobe_d = 1'b0;
    if (state_q == ST_RUN && instr_valid) begin
      if (op[3:2] != 2'b11) begin
        c_d  = cy;
        z_d  = (r == '0);
        pc_d = pc_inc;
        case (op)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000: a_d = r;
          4'b0100, 4'b0101, 4'b0110, 4'b0111:          b_d = r;
          default: begin
            out_d    = r;
            strobe_d = 1'b1;
          end
        endcase
      end else begin
        case (op[1:0])
          2'b00:   pc_d = z_q ? target : pc_inc;
          2'b01:   state_d = ST_HALT;
          2'b10:   pc_d = c_q ? pc_inc : target;
          default: pc_d = target;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      pc_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      pc_q     <= pc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      strobe_q <= strobe_d;
    end
  end

  assign pc         = pc_q;
  assign out_port   = out_q;
  assign out_strobe = strobe_q;
  assign carry      = c_q;
  assign zero       = z_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4_cpu_param.sv
// Directed bench for td4_cpu_param: a 4/4 instance for the main program
// and an 8/6 instance for the wide-datapath case.
module tb_td4_cpu_param;

  logic        clk = 1'b0;
  logic        rst, instr_valid;
  logic [7:0]  instr;
  logic [3:0]  in_port, pc, out_port;
  logic        out_strobe, carry, zero, halted;

  logic        rst8, instr_valid8;
  logic [11:0] instr8;
  logic [7:0]  in_port8, out_port8;
  logic [5:0]  pc8;
  logic        out_strobe8, carry8, zero8, halted8;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q[$];
  logic [7:0] exp8_q[$];

  always #5 clk = ~clk;

  td4_cpu_param #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .in_port(in_port), .pc(pc), .out_port(out_port), .out_strobe(out_strobe),
    .carry(carry), .zero(zero), .halted(halted)
  );

  td4_cpu_param #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .clk(clk), .rst(rst8), .instr_valid(instr_valid8), .instr(instr8),
    .in_port(in_port8), .pc(pc8), .out_port(out_port8), .out_strobe(out_strobe8),
    .carry(carry8), .zero(zero8), .halted(halted8)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every strobe pops one expected output value.
  always @(negedge clk) begin
    if (out_strobe === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
      else chk("out_port_strobe", int'(out_port), int'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (out_strobe8 === 1'b1) begin
      if (exp8_q.size() == 0) chk("unexpected_strobe8", 1, 0);
      else chk("out_port8_strobe", int'(out_port8), int'(exp8_q.pop_front()));
    end
  end

  task automatic step(input logic v, input logic [7:0] ins);
    instr_valid = v;
    instr       = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic v, input logic [11:0] ins);
    instr_valid8 = v;
    instr8       = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 8'h00; in_port = 4'h0;
    rst8 = 1'b1; instr_valid8 = 1'b0; instr8 = 12'h000; in_port8 = 8'h00;

    // Reset and stall
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_strobe", out_strobe, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_halted", halted, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h35);
      chk("stall_pc", pc, 0);
    end
    exp_q.push_back(4'd0);
    step(1'b1, 8'hA0);
    chk("stall_a_flags_c", carry, 0);
    chk("stall_a_flags_z", zero, 1);
    step(1'b0, 8'hA0);
    chk("stall_after_out_strobe", out_strobe, 0);
    chk("stall_after_out_pc", pc, 1);

    // Add, carry and zero
    do_reset();
    step(1'b1, 8'h3F);
    step(1'b1, 8'h01);
    chk("add_carry", carry, 1);
    chk("add_zero", zero, 1);
    chk("add_pc", pc, 2);
    step(1'b1, 8'hE0);
    chk("jnc_not_taken_pc", pc, 3);
    chk("jnc_keeps_c", carry, 1);
    chk("jnc_keeps_z", zero, 1);
    exp_q.push_back(4'd0);
    step(1'b1, 8'hA0);
    chk("out_a_pc", pc, 4);
    step(1'b0, 8'h00);
    chk("strobe_single", out_strobe, 0);

    // SUB borrow
    step(1'b1, 8'h33);
    step(1'b1, 8'h85);
    chk("sub_borrow_c", carry, 0);
    chk("sub_borrow_z", zero, 0);
    exp_q.push_back(4'd14);
    step(1'b1, 8'hA0);
    chk("sub_out", out_port, 14);
    step(1'b1, 8'h8E);
    chk("sub_eq_c", carry, 1);
    chk("sub_eq_z", zero, 1);
    chk("sub_eq_pc", pc, 8);
    step(1'b1, 8'hC9);
    chk("jz_taken_pc", pc, 9);

    // IN / OUT path, back-to-back OUTs
    in_port = 4'b0101;
    step(1'b1, 8'h62);
    exp_q.push_back(4'd7);
    step(1'b1, 8'h90);
    chk("out_b_value", out_port, 7);
    exp_q.push_back(4'd3);
    step(1'b1, 8'hB3);
    chk("out_im_value", out_port, 3);
    step(1'b0, 8'h00);
    chk("b2b_strobe_fall", out_strobe, 0);

    // PC wrap and JMP
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'h00);
      chk("wrap_pc", pc, (i + 1) % 16);
      chk("wrap_zero", zero, 1);
    end
    for (int i = 0; i < 15; i++)
      step(1'b1, (i == 13) ? 8'h3F : (i == 14) ? 8'h02 : 8'h00);
    chk("pre_jmp_pc", pc, 15);
    chk("pre_jmp_c", carry, 1);
    chk("pre_jmp_z", zero, 0);
    step(1'b1, 8'hF6);
    chk("jmp_pc", pc, 6);
    chk("jmp_keeps_c", carry, 1);
    chk("jmp_keeps_z", zero, 0);

    // Halt and reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h00);
    step(1'b1, 8'hD0);
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", pc, 4);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)));
      chk("halt_hold_halted", halted, 1);
      chk("halt_hold_pc", pc, 4);
      chk("halt_hold_strobe", out_strobe, 0);
    end
    do_reset();
    chk("unhalt", halted, 0);
    step(1'b1, 8'h35);
    exp_q.push_back(4'd5);
    step(1'b1, 8'hA0);
    chk("pre_rst_out", out_port, 5);
    step(1'b1, 8'h39);
    rst = 1'b1;
    step(1'b1, 8'hA0);
    rst = 1'b0;
    chk("rst_mid_out_port", out_port, 0);
    chk("rst_mid_strobe", out_strobe, 0);
    chk("rst_mid_halted", halted, 0);
    chk("rst_mid_pc", pc, 0);
    step(1'b0, 8'h00);
    chk("rst_mid_no_strobe", out_strobe, 0);

    // Wide instance: DATA_W=8, ADDR_W=6
    step8(1'b0, 12'h000);
    rst8 = 1'b0;
    chk("w8_rst_pc", pc8, 0);
    step8(1'b1, {4'h3, 8'd200});
    step8(1'b1, {4'h0, 8'd100});
    chk("w8_add_c", carry8, 1);
    chk("w8_add_z", zero8, 0);
    exp8_q.push_back(8'd44);
    step8(1'b1, {4'hA, 8'd0});
    chk("w8_out", out_port8, 44);
    chk("w8_pc", pc8, 3);
    step8(1'b1, {4'hF, 8'hC5});
    chk("w8_jmp_low_bits", pc8, 5);

    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp8_q_drained", exp8_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
